// File: rtl/box_rasterizer.sv
// Rasterises one filled rectangle per accepted command into single-pixel VGA writes,
// one pixel per clock in row-major order, clipping pixels that fall off the 320x240 screen.
module box_rasterizer #(
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] in_box_x,
  input  logic [8:0] in_box_y,
  input  logic [8:0] in_box_w,
  input  logic [8:0] in_box_h,
  input  logic [2:0] in_box_color,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t     state;
  logic [8:0] cx;
  logic [8:0] cy;
  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [8:0] box_w;
  logic [8:0] box_h;
  logic [2:0] box_color;
  logic [9:0] px;
  logic [9:0] py;
  logic       take;
  logic       last_col;
  logic       last_row;

  function automatic logic on_screen(input logic [9:0] col, input logic [9:0] row);
    return (col < {1'b0, SCREEN_WIDTH}) && (row < {1'b0, SCREEN_HEIGHT});
  endfunction

  assign s_ready  = (state == IDLE);
  assign take     = s_valid && s_ready;
  // Ten-bit sums so coordinates past the screen edge cannot wrap back on-screen.
  assign px       = {1'b0, box_x} + {1'b0, cx};
  assign py       = {1'b0, box_y} + {1'b0, cy};
  assign last_col = (cx == box_w - 9'd1);
  assign last_row = (cy == box_h - 9'd1);

  // Command capture: box parameters are frozen for the whole draw.
  always_ff @(posedge clock) begin
    if (take) begin
      box_x     <= in_box_x;
      box_y     <= in_box_y;
      box_w     <= in_box_w;
      box_h     <= in_box_h;
      box_color <= in_box_color;
    end
  end

  // Raster walk: each DRAW edge emits pixel (cx,cy) and then advances the counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cx     <= 9'd0;
      cy     <= 9'd0;
      vga_x  <= 9'd0;
      vga_y  <= 8'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            cx <= 9'd0;
            cy <= 9'd0;
            if ((in_box_w != 9'd0) && (in_box_h != 9'd0)) begin
              state <= DRAW;
            end else begin
              done <= 1'b1;
            end
          end
        end
        DRAW: begin
          vga_x  <= px[8:0];
          vga_y  <= py[7:0];
          colour <= box_color;
          plot   <= on_screen(px, py);
          if (last_col) begin
            cx <= 9'd0;
            if (last_row) begin
              cy    <= 9'd0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cy <= cy + 9'd1;
            end
          end else begin
            cx <= cx + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
